floating_unit: RTL and testbench

FLOATING_UNIT -- requirements
Module: floating_unit

---
 rtl/fp32_pkg.sv | 26 ++
 rtl/fp_lzc_shift.sv | 33 +++
 rtl/floating_unit.sv | 105 ++++++++++
 tb/tb_floating_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 constants, operand-unpack struct and unpack helper
// used by the floating-point adder.
package fp32_pkg;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned SIG_W  = FRAC_W + 1;
    localparam int unsigned EXT_W  = SIG_W + 3;
    localparam int unsigned BIAS   = 127;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0]      QNAN    = 32'hFF800001;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } fp_unpacked_t;

    // Subnormals get effective exponent 1 and no hidden bit.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
        fp_unpacked_t u;
        u.sign = x[31];
        u.exp  = (x[30:23] == '0) ? EXP_W'(1) : x[30:23];
        u.sig  = {(x[30:23] != '0), x[22:0]};
        return u;
    endfunction
endpackage

// File: rtl/fp_lzc_shift.sv
// Leading-zero count and left-normalize of the extended mantissa, with the
// shift clamped so the exponent never drops below 1 (subnormal -> exp 0).
module fp_lzc_shift
    import fp32_pkg::*;
(
    input  logic [EXT_W-1:0] i_mant,
    input  logic [EXP_W-1:0] i_exp,
    output logic [EXT_W-1:0] o_mant,
    output logic [EXP_W-1:0] o_exp
);
    logic [4:0]       w_lzc;
    logic             w_found;
    logic [EXP_W-1:0] w_limit;
    logic [EXP_W-1:0] w_shamt;

    always_comb begin
        w_lzc   = 5'(EXT_W);
        w_found = 1'b0;
        for (int i = int'(EXT_W) - 1; i >= 0; i--) begin
            if (!w_found && i_mant[i]) begin
                w_lzc   = 5'(int'(EXT_W) - 1 - i);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_limit = i_exp - EXP_W'(1);
        w_shamt = (EXP_W'(w_lzc) < w_limit) ? EXP_W'(w_lzc) : w_limit;
        o_mant  = i_mant << w_shamt;
        o_exp   = o_mant[EXT_W-1] ? (i_exp - w_shamt) : '0;
    end
endmodule

// File: rtl/floating_unit.sv
// Single-cycle binary32 adder/subtractor, round-to-nearest-even,
// with the result registered once.
module floating_unit
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic [31:0] result
);
    logic [31:0]      w_b_eff;
    fp_unpacked_t     w_ua, w_ub, w_big, w_small;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_same;
    logic [EXP_W-1:0] w_diff;
    logic [EXT_W-1:0] w_small_ext, w_lost, w_aligned;
    logic [EXT_W:0]   w_sum;
    logic [EXT_W-1:0] w_norm_in, w_norm_mant;
    logic [EXP_W-1:0] w_norm_exp_in, w_norm_exp;
    logic             w_round_up;
    logic [SIG_W:0]   w_rounded;
    logic [EXP_W:0]   w_exp9;
    logic [31:0]      w_next;

    assign w_b_eff = {b[31] ^ op, b[30:0]};
    assign w_ua    = fp_unpack(a);
    assign w_ub    = fp_unpack(w_b_eff);

    assign w_a_nan = (a[30:23] == EXP_MAX) && (a[22:0] != '0);
    assign w_b_nan = (w_b_eff[30:23] == EXP_MAX) && (w_b_eff[22:0] != '0);
    assign w_a_inf = (a[30:23] == EXP_MAX) && (a[22:0] == '0);
    assign w_b_inf = (w_b_eff[30:23] == EXP_MAX) && (w_b_eff[22:0] == '0);
    assign w_same  = (w_ua.sign == w_ub.sign);

    // Order by magnitude, align the smaller operand, then add or subtract.
    always_comb begin
        if ({w_ua.exp, w_ua.sig} >= {w_ub.exp, w_ub.sig}) begin
            w_big   = w_ua;
            w_small = w_ub;
        end else begin
            w_big   = w_ub;
            w_small = w_ua;
        end
        w_diff      = w_big.exp - w_small.exp;
        w_small_ext = {w_small.sig, 3'b000};
        w_lost      = '0;
        if (w_diff >= EXP_W'(26)) begin
            w_aligned = {{(EXT_W-1){1'b0}}, |w_small.sig};
        end else begin
            w_aligned    = w_small_ext >> w_diff[4:0];
            w_lost       = w_small_ext & ~({EXT_W{1'b1}} << w_diff[4:0]);
            w_aligned[0] = w_aligned[0] | (|w_lost);
        end
        if (w_same)
            w_sum = {1'b0, w_big.sig, 3'b000} + {1'b0, w_aligned};
        else
            w_sum = {1'b0, w_big.sig, 3'b000} - {1'b0, w_aligned};
        if (w_sum[EXT_W]) begin
            w_norm_in     = {w_sum[EXT_W:2], |w_sum[1:0]};
            w_norm_exp_in = w_big.exp + EXP_W'(1);
        end else begin
            w_norm_in     = w_sum[EXT_W-1:0];
            w_norm_exp_in = w_big.exp;
        end
    end

    fp_lzc_shift u_lzc_shift (
        .i_mant (w_norm_in),
        .i_exp  (w_norm_exp_in),
        .o_mant (w_norm_mant),
        .o_exp  (w_norm_exp)
    );

    // Round-to-nearest-even on guard/round/sticky, then special-case priority.
    always_comb begin
        w_round_up = w_norm_mant[2] & (w_norm_mant[1] | w_norm_mant[0] | w_norm_mant[3]);
        w_rounded  = {1'b0, w_norm_mant[EXT_W-1:3]} + (SIG_W+1)'(w_round_up);
        w_exp9     = {1'b0, w_norm_exp};
        if (w_rounded[SIG_W])
            w_exp9 = w_exp9 + (EXP_W+1)'(1);
        else if ((w_norm_exp == '0) && w_rounded[FRAC_W])
            w_exp9 = (EXP_W+1)'(1);

        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a[31] != w_b_eff[31])))
            w_next = QNAN;
        else if (w_a_inf)
            w_next = {a[31], EXP_MAX, {FRAC_W{1'b0}}};
        else if (w_b_inf)
            w_next = {w_b_eff[31], EXP_MAX, {FRAC_W{1'b0}}};
        else if (w_sum == '0)
            w_next = {w_same & w_big.sign, 31'b0};
        else if (w_exp9 >= {1'b0, EXP_MAX})
            w_next = {w_big.sign, EXP_MAX, {FRAC_W{1'b0}}};
        else
            w_next = {w_big.sign, w_exp9[EXP_W-1:0], w_rounded[FRAC_W-1:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            result <= '0;
        else
            result <= w_next;
    end
endmodule

// File: tb/tb_floating_unit.sv
// Bench for floating_unit: exact-arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed results.
module tb_floating_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic        op;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] cmp_exp;
    logic        cmp_vld;

    floating_unit dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .op     (op),
        .result (result)
    );

    always #5 clk = ~clk;

    // Exact sum in units of 2^-149, then one correct RNE rounding to binary32.
    function automatic logic [31:0] model_add(input logic [31:0] x, input logic [31:0] y,
                                              input logic sub);
        logic [31:0]  yy;
        logic [319:0] vx, vy, mag, keep, rem, half;
        logic         sgn, up;
        int           p, sh, e;
        yy = {y[31] ^ sub, y[30:0]};
        if ((x[30:23] == 8'hFF && x[22:0] != 0) || (yy[30:23] == 8'hFF && yy[22:0] != 0))
            return 32'hFF800001;
        if (x[30:23] == 8'hFF && yy[30:23] == 8'hFF)
            return (x[31] == yy[31]) ? x : 32'hFF800001;
        if (x[30:23] == 8'hFF) return x;
        if (yy[30:23] == 8'hFF) return yy;
        vx = 320'({x[30:23] != 0, x[22:0]}) << ((x[30:23] == 0) ? 0 : int'(x[30:23]) - 1);
        vy = 320'({yy[30:23] != 0, yy[22:0]}) << ((yy[30:23] == 0) ? 0 : int'(yy[30:23]) - 1);
        if (x[31] == yy[31]) begin
            mag = vx + vy;
            sgn = x[31];
        end else if (vx >= vy) begin
            mag = vx - vy;
            sgn = x[31];
        end else begin
            mag = vy - vx;
            sgn = yy[31];
        end
        if (mag == 0)
            return (x[31] == yy[31]) ? {x[31], 31'b0} : 32'h0;
        p = -1;
        for (int i = 319; i >= 0; i--)
            if (p < 0 && mag[i]) p = i;
        if (p <= 23)
            return {sgn, mag[30:0]};
        sh   = p - 23;
        keep = mag >> sh;
        rem  = mag & ((320'(1) << sh) - 320'(1));
        half = 320'(1) << (sh - 1);
        up   = (rem > half) || (rem == half && keep[0]);
        keep = keep + 320'(up);
        if (keep[24]) begin
            keep = keep >> 1;
            sh   = sh + 1;
        end
        e = sh + 1;
        if (e >= 255)
            return {sgn, 8'hFF, 23'b0};
        return {sgn, 8'(e), keep[22:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic vec(input string name, input logic [31:0] va, input logic [31:0] vb,
                       input logic vop, input logic [31:0] want);
        a  = va;
        b  = vb;
        op = vop;
        @(posedge clk);
        #1;
        check(name, result, want);
        check({name, "_model"}, model_add(va, vb, vop), want);
    endtask

    // Every cycle: result must match the model of the inputs sampled at the last edge.
    initial begin
        cmp_vld = 1'b0;
        cmp_exp = '0;
        forever begin
            @(posedge clk);
            cmp_vld = !rst;
            cmp_exp = model_add(a, b, op);
            @(negedge clk);
            if (rst)
                check("cmp_reset", result, 32'h0);
            else if (cmp_vld)
                check("cmp_model", result, cmp_exp);
        end
    end

    initial begin
        rst = 1'b0;
        a   = '0;
        b   = '0;
        op  = 1'b0;
        #1 rst = 1'b1;
        #1 check("reset_state", result, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        vec("norm_pos",     32'h3FFFFFFF, 32'h3FFFFFFF, 1'b0, 32'h407FFFFF);
        vec("norm_neg",     32'hBFFFFFFF, 32'hBFFFFFFF, 1'b0, 32'hC07FFFFF);
        vec("cancel",       32'hBFFFFFFF, 32'h3FFFFFFF, 1'b0, 32'h00000000);
        vec("large_tiny",   32'h3240F357, 32'h0D0844ED, 1'b0, 32'h3240F357);
        vec("mixed_sign",   32'hC2F63EFA, 32'h3F8E38E4, 1'b0, 32'hC2F40616);
        vec("subn_add",     32'h000002CA, 32'h000002CA, 1'b0, 32'h00000594);
        vec("subn_norm",    32'h007FFFFF, 32'h00FFFFFF, 1'b0, 32'h013FFFFF);
        vec("nan_b",        32'hFF800000, 32'hFFFFFFFF, 1'b0, 32'hFF800001);
        vec("inf_fin",      32'h7F800000, 32'h42F60000, 1'b0, 32'h7F800000);
        vec("inf_minf",     32'h7F800000, 32'hFF800000, 1'b0, 32'hFF800001);
        vec("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000);
        vec("sub_cancel",   32'h3FFFFFFF, 32'h3FFFFFFF, 1'b1, 32'h00000000);
        vec("sub_2m1",      32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000);
        vec("tie_even",     32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000);
        vec("tie_odd",      32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002);
        vec("above_half",   32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001);
        vec("lzc_norm",     32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000);
        vec("to_subn",      32'h00800001, 32'h00800000, 1'b1, 32'h00000001);
        vec("neg_zeros",    32'h80000000, 32'h80000000, 1'b0, 32'h80000000);
        vec("mixed_zeros",  32'h00000000, 32'h80000000, 1'b0, 32'h00000000);
        vec("sub_inf_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'hFF800001);
        vec("ninf_fin",     32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000);
        vec("fin_ninf",     32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000);
        vec("nan_a",        32'h7FC00000, 32'h00000000, 1'b0, 32'hFF800001);
        vec("sticky_far",   32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000);
        vec("sticky_sub",   32'h3F800000, 32'h00000001, 1'b1, 32'h3F800000);
        vec("round_carry",  32'h4B7FFFFF, 32'h3F000000, 1'b0, 32'h4B800000);

        rst = 1'b1;
        #1 check("rst_async", result, 32'h0);
        a  = 32'h3F800000;
        b  = 32'h3F800000;
        op = 1'b0;
        @(posedge clk);
        #1 check("rst_hold", result, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1 check("rst_release", result, 32'h40000000);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
